// File: rtl/wm_phase_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : wm_phase_timer_if
// Purpose  : Request/status bundle between the washer control FSM and the
//            phase timer.
// Revision : 1.0
// ============================================================================
interface wm_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             prog_long;
    logic             run_wash;
    logic             run_spin;
    logic             fill_active;
    logic             drain_active;
    logic             pause;
    logic             fault_clr;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic             fault;
    logic [1:0]       fault_code;
    logic             busy;
    logic [CNT_W-1:0] ticks_left;

    modport master (
        output prog_long, run_wash, run_spin, fill_active, drain_active,
               pause, fault_clr,
        input  cycle_timeout, spin_timeout, fault, fault_code, busy, ticks_left
    );

    modport slave (
        input  prog_long, run_wash, run_spin, fill_active, drain_active,
               pause, fault_clr,
        output cycle_timeout, spin_timeout, fault, fault_code, busy, ticks_left
    );
endinterface
`default_nettype wire

// File: rtl/wm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : wm_phase_timer
// Purpose  : Wash/spin phase timer with fill/drain watchdog and sticky fault.
// Revision : 1.0
// ============================================================================
module wm_phase_timer #(
    parameter int CNT_W       = 16,
    parameter int PRESCALE    = 10,
    parameter int WASH_SHORT  = 100,
    parameter int WASH_LONG   = 300,
    parameter int SPIN_TICKS  = 50,
    parameter int FILL_LIMIT  = 200,
    parameter int DRAIN_LIMIT = 150
) (
    input  wire             clk,
    input  wire             reset,
    wm_phase_timer_if.slave bus
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(PRESCALE - 1);
    localparam longint          MAX_LOAD = (longint'(1) << CNT_W) - 1;

    localparam logic [CNT_W-1:0] LD_WASH_S = CNT_W'(WASH_SHORT);
    localparam logic [CNT_W-1:0] LD_WASH_L = CNT_W'(WASH_LONG);
    localparam logic [CNT_W-1:0] LD_SPIN   = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] LD_FILL   = CNT_W'(FILL_LIMIT);
    localparam logic [CNT_W-1:0] LD_DRAIN  = CNT_W'(DRAIN_LIMIT);

    generate
        if (longint'(WASH_SHORT) > MAX_LOAD || longint'(WASH_LONG) > MAX_LOAD ||
            longint'(SPIN_TICKS) > MAX_LOAD || longint'(FILL_LIMIT) > MAX_LOAD ||
            longint'(DRAIN_LIMIT) > MAX_LOAD) begin : g_load_range_err
            $error("wm_phase_timer: load value does not fit in CNT_W bits");
        end
        if (PRESCALE < 1) begin : g_prescale_err
            $error("wm_phase_timer: PRESCALE must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WASH      = 3'd1,
        ST_SPIN      = 3'd2,
        ST_FILL_WD   = 3'd3,
        ST_DRAIN_WD  = 3'd4,
        ST_WASH_DONE = 3'd5,
        ST_SPIN_DONE = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             cyc_to_q, cyc_to_d;
    logic             spin_to_q, spin_to_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             own_req;
    logic             tick;
    logic             expire;
    state_t           expire_state;
    logic [1:0]       expire_code;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            cyc_to_q  <= 1'b0;
            spin_to_q <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            cyc_to_q  <= cyc_to_d;
            spin_to_q <= spin_to_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        own_req      = 1'b0;
        expire_state = ST_IDLE;
        expire_code  = 2'b00;
        case (state_q)
            ST_WASH:     begin own_req = bus.run_wash;     expire_state = ST_WASH_DONE; end
            ST_SPIN:     begin own_req = bus.run_spin;     expire_state = ST_SPIN_DONE; end
            ST_FILL_WD:  begin own_req = bus.fill_active;  expire_state = ST_FAULT; expire_code = 2'b01; end
            ST_DRAIN_WD: begin own_req = bus.drain_active; expire_state = ST_FAULT; expire_code = 2'b10; end
            default:     ;
        endcase

        tick = !bus.pause && (presc_q == PS_MAX);
        // A zero load expires on the first edge; otherwise the last tick does.
        expire = (cnt_q == '0) || (tick && (cnt_q == CNT_W'(1)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        cyc_to_d  = cyc_to_q;
        spin_to_d = spin_to_q;
        fault_d   = fault_q;
        code_d    = code_q;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                if (bus.run_wash) begin
                    state_d = ST_WASH;
                    cnt_d   = bus.prog_long ? LD_WASH_L : LD_WASH_S;
                end else if (bus.run_spin) begin
                    state_d = ST_SPIN;
                    cnt_d   = LD_SPIN;
                end else if (bus.drain_active) begin
                    state_d = ST_DRAIN_WD;
                    cnt_d   = LD_DRAIN;
                end else if (bus.fill_active) begin
                    state_d = ST_FILL_WD;
                    cnt_d   = LD_FILL;
                end
            end

            ST_WASH, ST_SPIN, ST_FILL_WD, ST_DRAIN_WD: begin
                // Losing the request beats an expiry on the same edge.
                if (!own_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (expire) begin
                    state_d   = expire_state;
                    cnt_d     = '0;
                    presc_d   = '0;
                    cyc_to_d  = (state_q == ST_WASH);
                    spin_to_d = (state_q == ST_SPIN);
                    if (expire_state == ST_FAULT) begin
                        fault_d = 1'b1;
                        code_d  = expire_code;
                    end
                end else if (!bus.pause) begin
                    if (tick) begin
                        presc_d = '0;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
            end

            ST_WASH_DONE: begin
                if (!bus.run_wash) begin
                    state_d  = ST_IDLE;
                    cyc_to_d = 1'b0;
                end
            end

            ST_SPIN_DONE: begin
                if (!bus.run_spin) begin
                    state_d   = ST_IDLE;
                    spin_to_d = 1'b0;
                end
            end

            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                    code_d  = 2'b00;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cycle_timeout = cyc_to_q;
    assign bus.spin_timeout  = spin_to_q;
    assign bus.fault         = fault_q;
    assign bus.fault_code    = code_q;
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign bus.ticks_left    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_phase_timer
// Purpose  : Self-checking bench for wm_phase_timer against a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_wm_phase_timer;

    localparam int CNT_W       = 16;
    localparam int PRESCALE    = 2;
    localparam int WASH_SHORT  = 3;
    localparam int WASH_LONG   = 5;
    localparam int SPIN_TICKS  = 2;
    localparam int FILL_LIMIT  = 4;
    localparam int DRAIN_LIMIT = 4;
    localparam int VW          = CNT_W + 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    wm_phase_timer_if #(.CNT_W(CNT_W)) bus ();

    wm_phase_timer #(
        .CNT_W      (CNT_W),
        .PRESCALE   (PRESCALE),
        .WASH_SHORT (WASH_SHORT),
        .WASH_LONG  (WASH_LONG),
        .SPIN_TICKS (SPIN_TICKS),
        .FILL_LIMIT (FILL_LIMIT),
        .DRAIN_LIMIT(DRAIN_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: phase plus count of un-paused cycles spent in it.
    typedef enum {M_IDLE, M_WASH, M_SPIN, M_FILL, M_DRAIN, M_WASH_DONE, M_SPIN_DONE, M_FAULT} mph_t;
    mph_t       m_ph;
    int         m_load;
    int         m_run;
    logic [1:0] m_code;

    function automatic void m_reset();
        m_ph = M_IDLE; m_load = 0; m_run = 0; m_code = 2'b00;
    endfunction

    function automatic logic m_owner();
        case (m_ph)
            M_WASH:  return bus.run_wash;
            M_SPIN:  return bus.run_spin;
            M_FILL:  return bus.fill_active;
            M_DRAIN: return bus.drain_active;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void m_step();
        if (!reset) begin
            m_reset();
            return;
        end
        case (m_ph)
            M_IDLE: begin
                m_run = 0;
                if (bus.run_wash) begin
                    m_ph = M_WASH; m_load = bus.prog_long ? WASH_LONG : WASH_SHORT;
                end else if (bus.run_spin) begin
                    m_ph = M_SPIN; m_load = SPIN_TICKS;
                end else if (bus.drain_active) begin
                    m_ph = M_DRAIN; m_load = DRAIN_LIMIT;
                end else if (bus.fill_active) begin
                    m_ph = M_FILL; m_load = FILL_LIMIT;
                end
            end
            M_WASH, M_SPIN, M_FILL, M_DRAIN: begin
                if (!m_owner()) begin
                    m_ph = M_IDLE;
                end else begin
                    if (!bus.pause) m_run++;
                    if (m_load == 0 || m_run >= m_load * PRESCALE) begin
                        case (m_ph)
                            M_WASH:  m_ph = M_WASH_DONE;
                            M_SPIN:  m_ph = M_SPIN_DONE;
                            M_FILL:  begin m_ph = M_FAULT; m_code = 2'b01; end
                            default: begin m_ph = M_FAULT; m_code = 2'b10; end
                        endcase
                    end
                end
            end
            M_WASH_DONE: if (!bus.run_wash) m_ph = M_IDLE;
            M_SPIN_DONE: if (!bus.run_spin) m_ph = M_IDLE;
            M_FAULT: if (bus.fault_clr) begin m_ph = M_IDLE; m_code = 2'b00; end
            default: m_ph = M_IDLE;
        endcase
    endfunction

    function automatic logic [VW-1:0] m_vec();
        int tl;
        tl = 0;
        if (m_ph inside {M_WASH, M_SPIN, M_FILL, M_DRAIN}) tl = m_load - m_run / PRESCALE;
        return {m_ph == M_WASH_DONE, m_ph == M_SPIN_DONE, m_ph == M_FAULT, m_code,
                !(m_ph inside {M_IDLE, M_FAULT}), CNT_W'(tl)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.cycle_timeout, bus.spin_timeout, bus.fault, bus.fault_code,
                bus.busy, bus.ticks_left};
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.prog_long = 0; bus.run_wash = 0; bus.run_spin = 0; bus.fill_active = 0;
        bus.drain_active = 0; bus.pause = 0; bus.fault_clr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) cyc();
        n_tests++;
        if (dut_vec() !== '0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", dut_vec()); end
        reset = 1'b1;
        bus.run_wash = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL reset_pre[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        #2 reset = 1'b0;
        #1;
        m_reset();
        n_tests++;
        if (dut_vec() !== '0) begin n_fail++; $display("FAIL reset_async: got %h want 0", dut_vec()); end
        bus.run_wash = 1'b0;
        cyc();
        #2 reset = 1'b1;
        cyc();
        n_tests++;
        if (dut_vec() !== m_vec() || bus.ticks_left !== '0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_wash(input logic prog, input int exp_lat);
        int rise;
        rise = -1;
        bus.prog_long = prog;
        bus.run_wash  = 1'b1;
        cyc();
        n_tests++;
        if (bus.ticks_left !== CNT_W'(prog ? WASH_LONG : WASH_SHORT)) begin
            n_fail++; $display("FAIL wash_load: got %0d want %0d", bus.ticks_left, prog ? WASH_LONG : WASH_SHORT);
        end
        for (int i = 1; i <= exp_lat + 2; i++) begin
            cyc();
            if (bus.cycle_timeout === 1'b1 && rise < 0) rise = i;
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL wash_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        n_tests++;
        if (rise != exp_lat) begin n_fail++; $display("FAIL wash_latency: got %0d want %0d", rise, exp_lat); end
        bus.run_wash  = 1'b0;
        bus.prog_long = 1'b0;
        cyc();
        n_tests++;
        if (bus.cycle_timeout !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL wash_release: got cto=%b busy=%b want 0 0", bus.cycle_timeout, bus.busy);
        end
    endtask

    task automatic test_pause();
        int rise;
        rise = -1;
        bus.run_wash = 1'b1;
        cyc();
        for (int i = 1; i <= 12; i++) begin
            bus.pause = (i >= 2 && i <= 5);
            cyc();
            if (bus.cycle_timeout === 1'b1 && rise < 0) rise = i;
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL pause_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        n_tests++;
        if (rise != 10) begin n_fail++; $display("FAIL pause_latency: got %0d want 10", rise); end
        bus.pause    = 1'b0;
        bus.run_wash = 1'b0;
        cyc();
    endtask

    task automatic test_watchdog(input logic drain);
        int rise;
        rise = -1;
        if (drain) bus.drain_active = 1'b1; else bus.fill_active = 1'b1;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (bus.fault === 1'b1 && rise < 0) rise = i;
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL wd_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        n_tests++;
        if (rise != 8 || bus.fault_code !== (drain ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL wd_fault: got edge %0d code %b want edge 8 code %b", rise, bus.fault_code, drain ? 2'b10 : 2'b01);
        end
        bus.drain_active = 1'b0;
        bus.fill_active  = 1'b0;
        cyc();
        n_tests++;
        if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got fault=%b want 1", bus.fault); end
        bus.fault_clr = 1'b1;
        cyc();
        bus.fault_clr = 1'b0;
        n_tests++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.fault_code !== 2'b00) begin
            n_fail++; $display("FAIL wd_clear: got fault=%b busy=%b code=%b want 0 0 00", bus.fault, bus.busy, bus.fault_code);
        end
    endtask

    task automatic test_fill_abort();
        bus.fill_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL abort_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        bus.fill_active = 1'b0;
        cyc();
        n_tests++;
        if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.ticks_left !== '0) begin
            n_fail++; $display("FAIL abort_idle: got fault=%b busy=%b ticks=%0d want 0 0 0", bus.fault, bus.busy, bus.ticks_left);
        end
    endtask

    task automatic test_priority();
        int spin_seen;
        spin_seen = 0;
        bus.run_wash = 1'b1; bus.run_spin = 1'b1; bus.drain_active = 1'b1;
        cyc();
        n_tests++;
        if (bus.ticks_left !== CNT_W'(WASH_SHORT)) begin
            n_fail++; $display("FAIL prio_select: got ticks=%0d want %0d", bus.ticks_left, WASH_SHORT);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (bus.spin_timeout !== 1'b0) spin_seen++;
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL prio_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        n_tests++;
        if (spin_seen != 0) begin n_fail++; $display("FAIL prio_spin: got %0d spin pulses want 0", spin_seen); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_spin_drop();
        int seen;
        seen = 0;
        bus.run_spin = 1'b1;
        cyc();
        for (int i = 1; i <= 3; i++) begin
            cyc();
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL sdrop_model[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
        bus.run_spin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.spin_timeout !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL sdrop_idle: got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) bus.run_wash     = ~bus.run_wash;
            if ($urandom_range(0, 11) == 0) bus.run_spin     = ~bus.run_spin;
            if ($urandom_range(0, 11) == 0) bus.fill_active  = ~bus.fill_active;
            if ($urandom_range(0, 11) == 0) bus.drain_active = ~bus.drain_active;
            if ($urandom_range(0, 3) == 0)  bus.prog_long    = 1'($urandom_range(0, 1));
            bus.pause     = ($urandom_range(0, 5) == 0);
            bus.fault_clr = ($urandom_range(0, 7) == 0);
            cyc();
            n_tests++;
            if (dut_vec() !== m_vec()) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), m_vec()); end
        end
    endtask

    initial begin
        clear_inputs();
        m_reset();
        test_reset();
        test_wash(1'b0, 6);
        test_wash(1'b1, 10);
        test_pause();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_fill_abort();
        test_priority();
        test_spin_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
